// File: rtl/serial_increment_ctrl.sv
// Bit-serial increment controller: streams an operand LSB-first through an external
// 1-bit increment cell, rippling the carry in a flop and bypassing the cell once it dies.
module serial_increment_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] operand,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             bit_a,
   input  logic             bit_out,
   input  logic             bit_cout
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opnd_sr_q, opnd_sr_d;
   logic [WIDTH-1:0] res_sr_q, res_sr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             new_bit;
   logic [WIDTH-1:0] res_shifted;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         opnd_sr_q <= '0;
         res_sr_q  <= '0;
         result_q  <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         opnd_sr_q <= opnd_sr_d;
         res_sr_q  <= res_sr_d;
         result_q  <= result_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      opnd_sr_d   = opnd_sr_q;
      res_sr_d    = res_sr_q;
      result_d    = result_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      new_bit     = 1'b0;
      res_shifted = res_sr_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               opnd_sr_d = operand;
               res_sr_d  = '0;
               carry_d   = 1'b1;
               idx_d     = '0;
               state_d   = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end

         SHIFT: begin
            // Once the carry is gone the remaining bits pass straight through.
            if (carry_q) begin
               new_bit = bit_out;
               carry_d = bit_cout;
            end else begin
               new_bit = opnd_sr_q[0];
               carry_d = 1'b0;
            end
            res_shifted = {new_bit, res_sr_q[WIDTH-1:1]};
            res_sr_d    = res_shifted;
            opnd_sr_d   = {1'b0, opnd_sr_q[WIDTH-1:1]};
            if (idx_q == LAST_IDX) begin
               result_d = res_shifted;
               cout_d   = carry_d;
               state_d  = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign bit_a  = busy & opnd_sr_q[0];
   assign result = result_q;
   assign cout   = cout_q;

endmodule

// File: tb/tb_serial_increment_ctrl.sv
// Directed bench for serial_increment_ctrl with a behavioural 1-bit increment cell
// that can be made to corrupt one chosen bit position.
module tb_serial_increment_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] operand;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       cout;
   logic       bit_a;
   logic       bit_out;
   logic       bit_cout;

   int checks = 0;
   int errors = 0;
   int cur_bit = -1;
   int flip_idx = -1;

   serial_increment_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .operand  (operand),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .bit_a    (bit_a),
      .bit_out  (bit_out),
      .bit_cout (bit_cout)
   );

   // Increment cell; bit_out is inverted on the selected bit position to probe the bypass.
   assign bit_out  = (~bit_a) ^ ((flip_idx >= 0) && (cur_bit == flip_idx));
   assign bit_cout = bit_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] op, input int flip,
                         input logic [7:0] exp_res, input logic exp_c);
      @(negedge clk);
      operand  = op;
      start    = 1'b1;
      flip_idx = flip;
      chk({tag, "_idle_busy"}, busy, 0);
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         cur_bit = k;
         chk($sformatf("%s_busy%0d", tag, k), busy, 1);
         chk($sformatf("%s_done%0d", tag, k), done, 0);
         chk($sformatf("%s_bita%0d", tag, k), bit_a, op[k]);
      end
      @(negedge clk);
      cur_bit  = -1;
      flip_idx = -1;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_cout"}, cout, exp_c);
      chk({tag, "_bita_idle"}, bit_a, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_result_hold"}, result, exp_res);
      $display("op %s operand=0x%02h result=0x%02h cout=%0d (expect 0x%02h/%0d)",
               tag, op, result, cout, exp_res, exp_c);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      operand = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 8'h00);
      chk("rst_cout", cout, 0);
      chk("rst_bita", bit_a, 0);
      reset = 1'b0;
      $display("reset released busy=%0d done=%0d result=0x%02h", busy, done, result);

      run_op("inc00", 8'h00, -1, 8'h01, 1'b0);
      run_op("incFF", 8'hFF, -1, 8'h00, 1'b1);
      run_op("inc7F", 8'h7F, -1, 8'h80, 1'b0);

      // start held high: second op accepted in the DONE cycle, mid-SHIFT operand ignored
      @(negedge clk);
      operand = 8'h0F;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      operand = 8'hAA;
      chk("held_busy0", busy, 1);
      repeat (7) @(negedge clk);
      chk("held_done_early", done, 0);
      @(negedge clk);
      chk("held_done1", done, 1);
      chk("held_result1", result, 8'h10);
      chk("held_cout1", cout, 0);
      operand = 8'h10;
      $display("held op1 result=0x%02h done=%0d", result, done);
      @(negedge clk);
      operand = 8'h55;
      chk("held_busy_restart", busy, 1);
      chk("held_done_gap", done, 0);
      chk("held_result_hold", result, 8'h10);
      repeat (7) @(negedge clk);
      chk("held_done_early2", done, 0);
      @(negedge clk);
      chk("held_done2", done, 1);
      chk("held_result2", result, 8'h11);
      start = 1'b0;
      $display("held op2 result=0x%02h done=%0d", result, done);
      @(negedge clk);
      chk("held_idle_busy", busy, 0);
      chk("held_idle_done", done, 0);

      // reset during the fourth SHIFT cycle aborts the operation
      @(negedge clk);
      operand = 8'h3C;
      start   = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         chk($sformatf("abort_bita%0d", k), bit_a, (k == 2 || k == 3) ? 1 : 0);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 8'h00);
      chk("abort_cout", cout, 0);
      chk("abort_bita", bit_a, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("abort_nodone%0d", k), done | busy, 0);
      end
      $display("abort complete busy=%0d done=%0d result=0x%02h", busy, done, result);
      run_op("inc3C", 8'h3C, -1, 8'h3D, 1'b0);

      // cell corruption: ignored once carry is 0, visible while carry is 1
      run_op("byp00_b3", 8'h00, 3, 8'h01, 1'b0);
      run_op("cell00_b0", 8'h00, 0, 8'h00, 1'b0);
      run_op("cell07_b2", 8'h07, 2, 8'h0C, 1'b0);
      run_op("byp07_b5", 8'h07, 5, 8'h08, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
